// File: rtl/fetch_unit_if.sv
// Fetch unit signal bundle: instruction-memory req/ack, decode-side output, and redirect/stall controls.
interface fetch_unit_if #(
  parameter int WIDTH  = 8,
  parameter int IWIDTH = 16
);
  logic              stall;
  logic              branch_en;
  logic [WIDTH-1:0]  branch_addr;
  logic              mem_req;
  logic [WIDTH-1:0]  mem_addr;
  logic              mem_ack;
  logic [IWIDTH-1:0] mem_data;
  logic [IWIDTH-1:0] instr;
  logic              instr_valid;
  logic [WIDTH-1:0]  instr_pc;

  modport master (
    input  stall, branch_en, branch_addr, mem_ack, mem_data,
    output mem_req, mem_addr, instr, instr_valid, instr_pc
  );

  modport slave (
    output stall, branch_en, branch_addr, mem_ack, mem_data,
    input  mem_req, mem_addr, instr, instr_valid, instr_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC, req/ack memory handshake, one-entry instruction register,
// branch redirect with drain of any in-flight request.
module fetch_unit #(
  parameter int               WIDTH     = 8,
  parameter int               IWIDTH    = 16,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  typedef enum logic [1:0] {BOOT, FETCH, HOLD, FLUSH} state_t;

  state_t            state;
  logic [WIDTH-1:0]  pc;
  logic [WIDTH-1:0]  addr;
  logic [WIDTH-1:0]  instr_pc;
  logic [IWIDTH-1:0] instr;
  logic              instr_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_VEC;
      addr        <= RESET_VEC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
          if (bus.branch_en) begin
            pc   <= bus.branch_addr;
            addr <= bus.branch_addr;
          end else begin
            addr <= pc;
          end
        end
        FETCH: begin
          if (bus.branch_en) begin
            pc <= bus.branch_addr;
            // Ack on the redirect edge: drop the word and restart at the target right away.
            if (bus.mem_ack) addr  <= bus.branch_addr;
            else             state <= FLUSH;
          end else if (bus.mem_ack) begin
            instr       <= bus.mem_data;
            instr_pc    <= addr;
            instr_valid <= 1'b1;
            pc          <= addr + WIDTH'(1);
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.branch_en) begin
            instr_valid <= 1'b0;
            pc          <= bus.branch_addr;
            addr        <= bus.branch_addr;
            state       <= FETCH;
          end else if (!bus.stall) begin
            instr_valid <= 1'b0;
            addr        <= pc;
            state       <= FETCH;
          end
        end
        FLUSH: begin
          // Old request stays on the bus until acked; the latest redirect target wins.
          if (bus.branch_en) pc <= bus.branch_addr;
          if (bus.mem_ack) begin
            addr  <= bus.branch_en ? bus.branch_addr : pc;
            state <= FETCH;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  assign bus.mem_req     = (state == FETCH) || (state == FLUSH);
  assign bus.mem_addr    = addr;
  assign bus.instr       = instr;
  assign bus.instr_pc    = instr_pc;
  assign bus.instr_valid = instr_valid;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the URCPU front end. It holds the program counter, runs a req/ack handshake with instruction memory, and captures each returned word into a one-entry output register for the decode stage. Branch redirects squash the held instruction and drain any in-flight memory request. All state is built on the team's async-reset flop style: one clock, asynchronous active-high reset.

## Interface
- WIDTH, 8, address / PC width in bits
- IWIDTH, 16, instruction word width in bits
- RESET_VEC, 0, PC value loaded on reset (WIDTH bits)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  decode not ready; held instruction is not consumed this edge
- branch_en  in  1  redirect request, sampled on rising edge
- branch_addr  in  WIDTH  redirect target
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  WIDTH  fetch address; stable while mem_req is high
- mem_ack  in  1  memory completion; mem_data valid on the same edge
- mem_data  in  IWIDTH  returned instruction word
- instr  out  IWIDTH  held instruction
- instr_valid  out  1  instr/instr_pc valid for decode
- instr_pc  out  WIDTH  address instr was fetched from

## Operation
- Registers: state, pc (next fetch address), mem_addr, instr, instr_pc, instr_valid. mem_req is a Moore decode: 1 in FETCH and FLUSH, else 0.
- Reset (async, overrides everything): state=BOOT, pc=mem_addr=RESET_VEC, instr=0, instr_pc=0, instr_valid=0, so mem_req=0 immediately.
- Event priority at each edge: reset > branch_en > mem_ack / consume.
- BOOT: mem_req=0.
  - Next edge: go to FETCH, mem_addr<=pc.
  - If branch_en: pc<=branch_addr and mem_addr<=branch_addr.
- FETCH: mem_req=1, mem_addr held.
  - branch_en & mem_ack: discard data, pc<=mem_addr<=branch_addr, stay FETCH.
  - branch_en & !mem_ack: pc<=branch_addr, go to FLUSH.
  - mem_ack only: instr<=mem_data, instr_pc<=mem_addr, instr_valid<=1, pc<=mem_addr+1, go to HOLD.
  - Otherwise: stay.
- HOLD: mem_req=0, instr_valid=1.
  - branch_en: instr_valid<=0, pc<=mem_addr<=branch_addr, go to FETCH.
  - !stall (consumed): instr_valid<=0, mem_addr<=pc, go to FETCH.
  - stall: hold everything.
- FLUSH: mem_req=1 with the old mem_addr, until ack.
  - branch_en: pc<=branch_addr; the latest branch wins.
  - mem_ack: discard data. mem_addr<=pc, or branch_addr if branch_en on the same edge. Go to FETCH.
- Arithmetic: pc increment is modulo 2^WIDTH. For WIDTH=8, 8'hFF+1 = 8'h00.
- instr and instr_pc keep their last value when instr_valid=0. They are not cleared on squash.

## Timing
- Handshake rule: once mem_req rises, it and mem_addr stay constant until the edge where mem_ack=1. The only exception is reset. mem_ack is ignored when mem_req=0.
- Zero-wait memory (mem_ack high on the first FETCH cycle): one instruction every 2 cycles (FETCH, HOLD).
- First request: mem_req rises 1 cycle after reset deasserts (BOOT lasts exactly one cycle).
- Capture latency: instr_valid rises on the same edge that samples mem_ack.
- Branch-to-request: in HOLD or BOOT, a request to branch_addr is issued the next cycle. In FETCH without ack, the new request waits for the old ack (FLUSH), then starts the cycle after.
- Squashed data never reaches instr and never sets instr_valid.
- Reset mid-transaction drops mem_req asynchronously. Memory must tolerate the abandoned request.

## Test plan
- Reset/boot: RESET_VEC=8'h10, reset pulse, mem_ack tied 1, stall 0 -> mem_req=0 during reset. mem_addr=8'h10 one cycle after release. Instructions appear with instr_pc 10,11,12, with instr_valid high every other cycle.
- Wait states + stall: ack delayed 3 cycles, then stall held 4 cycles -> mem_req/mem_addr stable for all 3 waits. instr held with instr_valid=1 for 4 cycles. Next request to pc+1 follows the first unstalled edge.
- Branch in FETCH without ack: request at 8'h05 pending, branch_en to 8'h40, ack 2 cycles later with 16'hDEAD -> mem_addr stays 05 until ack. DEAD is discarded and instr_valid stays 0. Next request is at 8'h40.
- Branch in HOLD: instr at 8'h20 held under stall, branch_en to 8'h80 -> instr_valid drops at that edge. The next cycle has mem_req=1, mem_addr=8'h80.
- Wrap-around: branch to 8'hFF, zero-wait memory -> instr_pc=FF, then instr_pc=00.
- Async reset mid-FLUSH: assert reset between edges -> mem_req, instr_valid, and state clear immediately, with no clock edge needed.
